// File: rtl/pc_fetch_if.sv
// Fetch/decode PC bus: pipeline control and branch operands in, fetch and ID-stage PC state out.
// Master drives the control side; slave is the PC fetch unit.
interface pc_fetch_if #(
  parameter int ADDR_W   = 64,
  parameter int COND_W   = 19,
  parameter int UNCOND_W = 26
);
  logic                stall;
  logic                flush;
  logic                pc_rd;
  logic [ADDR_W-1:0]   pc_ext;
  logic                BrTaken;
  logic                UncondBr;
  logic [COND_W-1:0]   CondAddr19;
  logic [UNCOND_W-1:0] BrAddr26;
  logic [ADDR_W-1:0]   pc_out;
  logic [ADDR_W-1:0]   id_pc;
  logic [ADDR_W-1:0]   id_link;
  logic                id_valid;
  logic [ADDR_W-1:0]   br_target;
  logic                redirect;
  logic                misalign;

  modport master (
    output stall, flush, pc_rd, pc_ext, BrTaken, UncondBr, CondAddr19, BrAddr26,
    input  pc_out, id_pc, id_link, id_valid, br_target, redirect, misalign
  );

  modport slave (
    input  stall, flush, pc_rd, pc_ext, BrTaken, UncondBr, CondAddr19, BrAddr26,
    output pc_out, id_pc, id_link, id_valid, br_target, redirect, misalign
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Fetch PC plus IF/ID PC register; redirects on pc_ext load or taken ID branch (one-bubble penalty).
// Latency: fetched PC reaches id_pc one edge later. Backpressure: stall freezes fetch PC and IF/ID.
module pc_fetch_unit #(
  parameter int                ADDR_W       = 64,
  parameter int                INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int                COND_W       = 19,
  parameter int                UNCOND_W     = 26
) (
  input  logic         clk,
  input  logic         reset,
  pc_fetch_if.slave    bus
);
  localparam int SHIFT = $clog2(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] INC  = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INSTR_BYTES - 1);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] id_pc_q;
  logic              id_valid_q;
  logic              redirect_q;
  logic              misalign_q;

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] target;
  logic              br_go;
  logic              aligned;

  always_comb begin
    offset = '0;
    if (bus.UncondBr)
      offset = {{(ADDR_W-UNCOND_W){bus.BrAddr26[UNCOND_W-1]}}, bus.BrAddr26};
    else
      offset = {{(ADDR_W-COND_W){bus.CondAddr19[COND_W-1]}}, bus.CondAddr19};
    target  = id_pc_q + (offset << SHIFT);
    br_go   = bus.BrTaken & id_valid_q;
    aligned = (bus.pc_ext & MASK) == '0;
  end

  // External load outranks stall and branch; a misaligned load only records the error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_VECTOR;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (bus.pc_rd && aligned) begin
      pc_q       <= bus.pc_ext;
      id_valid_q <= 1'b0;
      redirect_q <= 1'b1;
    end else if (bus.pc_rd) begin
      misalign_q <= 1'b1;
      redirect_q <= 1'b0;
    end else if (bus.stall) begin
      redirect_q <= 1'b0;
      if (bus.flush)
        id_valid_q <= 1'b0;
    end else if (br_go) begin
      pc_q       <= target;
      id_valid_q <= 1'b0;
      redirect_q <= 1'b1;
    end else begin
      pc_q       <= pc_q + INC;
      id_pc_q    <= pc_q;
      id_valid_q <= ~bus.flush;
      redirect_q <= 1'b0;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_link   = id_pc_q + INC;
  assign bus.id_valid  = id_valid_q;
  assign bus.br_target = target;
  assign bus.redirect  = redirect_q;
  assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: 64-bit instance with a 0x1000 reset vector and a 32-bit instance for wrap.
// Expected post-edge states are queued when stimulus is driven and popped after the edge.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_fetch_if #(.ADDR_W(64), .COND_W(19), .UNCOND_W(26)) ifa ();
  pc_fetch_if #(.ADDR_W(32), .COND_W(19), .UNCOND_W(26)) ifb ();

  pc_fetch_unit #(.ADDR_W(64), .INSTR_BYTES(4), .RESET_VECTOR(64'h1000),
                  .COND_W(19), .UNCOND_W(26)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  pc_fetch_unit #(.ADDR_W(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0),
                  .COND_W(19), .UNCOND_W(26)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  typedef struct {
    string       tag;
    bit          on_b;
    logic [63:0] pc;
    logic [63:0] idpc;
    logic        v;
    logic        r;
    logic        m;
  } exp_t;

  exp_t sb[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, bit on_b, logic [63:0] pc, logic [63:0] idpc,
                      logic v, logic r, logic m);
    exp_t e;
    e.tag = tag; e.on_b = on_b; e.pc = pc; e.idpc = idpc; e.v = v; e.r = r; e.m = m;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.on_b) begin
        check({e.tag, ".pc_out"},   {32'b0, ifb.pc_out}, e.pc);
        check({e.tag, ".id_pc"},    {32'b0, ifb.id_pc},  e.idpc);
        check({e.tag, ".id_valid"}, {63'b0, ifb.id_valid}, {63'b0, e.v});
        check({e.tag, ".redirect"}, {63'b0, ifb.redirect}, {63'b0, e.r});
        check({e.tag, ".misalign"}, {63'b0, ifb.misalign}, {63'b0, e.m});
      end else begin
        check({e.tag, ".pc_out"},   ifa.pc_out, e.pc);
        check({e.tag, ".id_pc"},    ifa.id_pc,  e.idpc);
        check({e.tag, ".id_valid"}, {63'b0, ifa.id_valid}, {63'b0, e.v});
        check({e.tag, ".redirect"}, {63'b0, ifa.redirect}, {63'b0, e.r});
        check({e.tag, ".misalign"}, {63'b0, ifa.misalign}, {63'b0, e.m});
      end
    end
  endtask

  task automatic drive_a(logic st, logic fl, logic rd, logic [63:0] ext,
                         logic bt, logic ub, logic [18:0] c19, logic [25:0] b26);
    @(negedge clk);
    ifa.stall = st; ifa.flush = fl; ifa.pc_rd = rd; ifa.pc_ext = ext;
    ifa.BrTaken = bt; ifa.UncondBr = ub; ifa.CondAddr19 = c19; ifa.BrAddr26 = b26;
  endtask

  task automatic drive_b(logic rd, logic [31:0] ext, logic bt, logic [18:0] c19);
    @(negedge clk);
    ifb.stall = 1'b0; ifb.flush = 1'b0; ifb.pc_rd = rd; ifb.pc_ext = ext;
    ifb.BrTaken = bt; ifb.UncondBr = 1'b0; ifb.CondAddr19 = c19; ifb.BrAddr26 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_a(0, 0, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    drive_b(0, 32'h0, 0, 19'h0);

    // reset state
    push("reset", 0, 64'h1000, 64'h0, 0, 0, 0);
    tick_check();
    check("reset.id_link", ifa.id_link, 64'h4);

    // sequential fetch
    @(negedge clk);
    rst_a = 1'b1;
    push("seq1", 0, 64'h1004, 64'h1000, 1, 0, 0); tick_check();
    push("seq2", 0, 64'h1008, 64'h1004, 1, 0, 0); tick_check();
    push("seq3", 0, 64'h100C, 64'h1008, 1, 0, 0); tick_check();
    check("seq3.id_link", ifa.id_link, 64'h100C);

    // conditional branch backward by two instructions
    drive_a(0, 0, 1, 64'h2000, 0, 0, 19'h0, 26'h0);
    push("ld2000", 0, 64'h2000, 64'h1008, 0, 1, 0); tick_check();
    drive_a(0, 0, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    push("fill", 0, 64'h2004, 64'h2000, 1, 0, 0); tick_check();
    drive_a(0, 0, 0, 64'h0, 1, 0, 19'h7FFFE, 26'h0);
    #1 check("cond.br_target", ifa.br_target, 64'h1FF8);
    push("cond", 0, 64'h1FF8, 64'h2000, 0, 1, 0); tick_check();
    drive_a(0, 0, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    push("cond.after", 0, 64'h1FFC, 64'h1FF8, 1, 0, 0); tick_check();

    // unconditional branch forward
    drive_a(0, 0, 1, 64'h2000, 0, 0, 19'h0, 26'h0);
    push("ld2000b", 0, 64'h2000, 64'h1FF8, 0, 1, 0); tick_check();
    drive_a(0, 0, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    push("fillb", 0, 64'h2004, 64'h2000, 1, 0, 0); tick_check();
    drive_a(0, 0, 0, 64'h0, 1, 1, 19'h0, 26'h10);
    #1 check("uncond.br_target", ifa.br_target, 64'h2040);
    push("uncond", 0, 64'h2040, 64'h2000, 0, 1, 0); tick_check();

    // branch held off by stall, taken once stall drops
    drive_a(0, 0, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    push("pre_stall", 0, 64'h2044, 64'h2040, 1, 0, 0); tick_check();
    drive_a(1, 0, 0, 64'h0, 1, 0, 19'h4, 26'h0);
    push("stall1", 0, 64'h2044, 64'h2040, 1, 0, 0); tick_check();
    push("stall2", 0, 64'h2044, 64'h2040, 1, 0, 0); tick_check();
    drive_a(0, 0, 0, 64'h0, 1, 0, 19'h4, 26'h0);
    push("unstall_br", 0, 64'h2050, 64'h2040, 0, 1, 0); tick_check();

    // load beats stall and branch; misaligned load rejected and sticky
    drive_a(1, 0, 1, 64'h3000, 1, 0, 19'h4, 26'h0);
    push("ld_prio", 0, 64'h3000, 64'h2040, 0, 1, 0); tick_check();
    drive_a(0, 0, 1, 64'h3002, 0, 0, 19'h0, 26'h0);
    push("misalign", 0, 64'h3000, 64'h2040, 0, 0, 1); tick_check();
    drive_a(0, 0, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    push("sticky", 0, 64'h3004, 64'h3000, 1, 0, 1); tick_check();

    // flush unstalled, branch ignored while invalid, stall+flush
    drive_a(0, 1, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    push("flush", 0, 64'h3008, 64'h3004, 0, 0, 1); tick_check();
    drive_a(0, 0, 0, 64'h0, 1, 0, 19'h40, 26'h0);
    push("br_invalid", 0, 64'h300C, 64'h3008, 1, 0, 1); tick_check();
    drive_a(1, 1, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    push("stall_flush", 0, 64'h300C, 64'h3008, 0, 0, 1); tick_check();

    // reset dominates a concurrent load
    drive_a(1, 0, 1, 64'h4000, 1, 0, 19'h4, 26'h0);
    rst_a = 1'b0;
    push("reset_mid", 0, 64'h1000, 64'h0, 0, 0, 0); tick_check();
    check("reset_mid.id_link", ifa.id_link, 64'h4);
    drive_a(0, 0, 0, 64'h0, 0, 0, 19'h0, 26'h0);
    rst_a = 1'b1;
    push("post_reset", 0, 64'h1004, 64'h1000, 1, 0, 0); tick_check();

    // 32-bit instance: fetch PC and branch target wrap
    push("b.reset", 1, 64'h0, 64'h0, 0, 0, 0); tick_check();
    drive_b(1, 32'hFFFF_FFFC, 0, 19'h0);
    rst_b = 1'b1;
    push("b.ld_top", 1, 64'hFFFF_FFFC, 64'h0, 0, 1, 0); tick_check();
    drive_b(0, 32'h0, 0, 19'h0);
    push("b.wrap", 1, 64'h0, 64'hFFFF_FFFC, 1, 0, 0); tick_check();
    check("b.id_link", {32'b0, ifb.id_link}, 64'h0);
    drive_b(0, 32'h0, 1, 19'h2);
    #1 check("b.br_target", {32'b0, ifb.br_target}, 64'h4);
    push("b.br_wrap", 1, 64'h4, 64'hFFFF_FFFC, 0, 1, 0); tick_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised, pipeline-ready successor to the single-cycle program counter.
- Holds the fetch PC and owns the IF/ID PC register with a valid bit.
- Resolves ARM B/CBZ/B.cond redirects against the PC of the instruction in ID.
- Supports stall, flush, external PC load with alignment checking, and BL link-address generation.
- Sits between the instruction memory address port and the decode stage of the pipelined CPU.

Parameters:
- ADDR_W, 64: PC width in bits.
- INSTR_BYTES, 4: sequential increment; must be a power of two.
- RESET_VECTOR, 0: PC value loaded at reset.
- COND_W, 19: conditional-branch offset width.
- UNCOND_W, 26: unconditional-branch offset width.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-low: reset==0 at a rising clk edge resets the block.
- stall  in  1  Holds fetch PC and IF/ID contents.
- flush  in  1  Invalidates IF/ID.
- pc_rd  in  1  Load fetch PC from pc_ext.
- pc_ext  in  ADDR_W  External PC value.
- BrTaken  in  1  Branch taken for the ID instruction.
- UncondBr  in  1  1 selects BrAddr26, 0 selects CondAddr19.
- CondAddr19  in  COND_W  Signed word offset.
- BrAddr26  in  UNCOND_W  Signed word offset.
- pc_out  out  ADDR_W  Fetch PC (instruction memory address).
- id_pc  out  ADDR_W  PC of the instruction in ID.
- id_link  out  ADDR_W  id_pc + INSTR_BYTES (BL return address).
- id_valid  out  1  ID holds a real instruction.
- br_target  out  ADDR_W  Combinational branch target.
- redirect  out  1  Registered pulse: fetch PC was redirected on the last edge.
- misalign  out  1  Sticky error: a rejected misaligned pc_ext.

Behaviour:
- Reset (reset==0 at edge):
  - pc_out=RESET_VECTOR; id_pc=0; id_valid=0; redirect=0; misalign=0.
  - id_link=INSTR_BYTES, since it follows id_pc.
  - Reset dominates all other inputs. Reset mid-stall or mid-redirect discards all pending state.
- Target:
  - br_target = id_pc + (sext(UncondBr ? BrAddr26 : CondAddr19) << log2(INSTR_BYTES)).
  - Computed modulo 2^ADDR_W; wrap-around is silent.
- Branch condition: br_go = BrTaken & id_valid. BrTaken is ignored when id_valid=0.
- Aligned load: pc_ext low log2(INSTR_BYTES) bits are zero.
- Next-state priority per edge, first match wins:
  1. pc_rd & aligned:
     - pc_out<=pc_ext; id_valid<=0; redirect<=1.
  2. pc_rd & misaligned:
     - pc_out holds; misalign<=1 (sticky until reset); IF/ID holds; redirect<=0.
  3. stall:
     - pc_out, id_pc and id_valid hold; redirect<=0.
     - If flush is also high, id_valid<=0 and id_pc holds.
     - A pending branch is re-evaluated on the next unstalled cycle.
  4. br_go:
     - pc_out<=br_target; id_valid<=0 (wrong-path fetch squashed); redirect<=1.
     - flush has no additional effect.
  5. Otherwise, sequential:
     - pc_out<=pc_out+INSTR_BYTES; id_pc<=pc_out; id_valid<=~flush; redirect<=0.
     - The fetch PC wraps from 2^ADDR_W−INSTR_BYTES to 0.
- Latency:
  - A fetched PC appears on id_pc one cycle later.
  - A branch resolved in ID redirects pc_out on the next edge, giving a one-bubble penalty.
- No combinational path from any input to pc_out, id_pc, id_valid, redirect or misalign.

Test Plan:
1. Reset with RESET_VECTOR=0x1000, then run 3 unstalled cycles:
   - pc_out 0x1000→0x1004→0x1008→0x100C.
   - id_pc=0x1008 and id_valid=1 after the third edge; id_link=0x100C.
2. id_pc=0x2000, id_valid=1, BrTaken=1, UncondBr=0, CondAddr19=0x7FFFE (−2):
   - br_target=0x1FF8; next pc_out=0x1FF8; id_valid=0; redirect=1 for one cycle.
   - UncondBr=1 with BrAddr26=0x10 gives a next pc_out of 0x2040.
3. Hold stall=1 for 2 cycles with BrTaken=1:
   - pc_out and id_pc are unchanged across both cycles.
   - The branch is taken on the first cycle after stall drops.
4. pc_rd=1, pc_ext=0x3000 together with BrTaken=1 and stall=1:
   - pc_out=0x3000; id_valid=0.
   - Then pc_rd=1, pc_ext=0x3002: pc_out holds at 0x3000; misalign=1 and remains set until reset.
5. BrTaken=1 with id_valid=0 → no redirect and a sequential increment. flush=1 on an unstalled cycle → id_valid=0 next cycle while pc_out still increments.
6. Drive reset=0 mid-sequence with pc_rd=1 at the same edge → all outputs at their reset values. With ADDR_W=32 and pc_out=0xFFFFFFFC, one unstalled cycle → pc_out=0x0.
